// File: rtl/biriscv_defs.sv
// rtl/biriscv_defs.sv - shared exception codes and retire-record field layout
// Contents:
//   EXCEPTION_W, EXCEPTION_* : writeback exception encoding (0 = none)
//   TRACE_*_LSB              : bit offsets of each field inside a packed retire record
//   TRACE_REC_W              : record width; CSR fields only exist when
//                              BIRISCV_COMMIT_TRACE_CSR_EN is defined
package biriscv_defs;

  localparam int EXCEPTION_W = 6;

  typedef logic [EXCEPTION_W-1:0] exception_t;

  localparam exception_t EXCEPTION_NONE              = 6'h00;
  localparam exception_t EXCEPTION_MISALIGNED_FETCH  = 6'h10;
  localparam exception_t EXCEPTION_FAULT_FETCH       = 6'h11;
  localparam exception_t EXCEPTION_ILLEGAL_INSTR     = 6'h12;
  localparam exception_t EXCEPTION_BREAKPOINT        = 6'h13;
  localparam exception_t EXCEPTION_MISALIGNED_LOAD   = 6'h14;
  localparam exception_t EXCEPTION_FAULT_LOAD        = 6'h15;
  localparam exception_t EXCEPTION_MISALIGNED_STORE  = 6'h16;
  localparam exception_t EXCEPTION_FAULT_STORE       = 6'h17;
  localparam exception_t EXCEPTION_ECALL             = 6'h18;

  // Record layout, LSB first: pc | opcode | rd | result | exception | [csr]
  localparam int TRACE_PC_LSB        = 0;
  localparam int TRACE_OPCODE_LSB    = 32;
  localparam int TRACE_RD_LSB        = 64;
  localparam int TRACE_RESULT_LSB    = 69;
  localparam int TRACE_EXC_LSB       = 101;
  localparam int TRACE_BASE_W        = 107;
  localparam int TRACE_CSR_WR_LSB    = 107;
  localparam int TRACE_CSR_WADDR_LSB = 108;
  localparam int TRACE_CSR_WDATA_LSB = 120;
  localparam int TRACE_CSR_W         = 45;

`ifdef BIRISCV_COMMIT_TRACE_CSR_EN
  localparam int TRACE_REC_W = TRACE_BASE_W + TRACE_CSR_W;
`else
  localparam int TRACE_REC_W = TRACE_BASE_W;
`endif

endpackage

// File: rtl/biriscv_commit_trace_fifo.sv
// rtl/biriscv_commit_trace_fifo.sv - register-array FIFO for retire records
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   flush         : synchronous empty, wins over push/pop
//   push, wr_data : write request and record (ignored when full unless popping)
//   pop           : read request (ignored when empty)
//   rd_data       : head entry, zero when empty
//   full, empty   : occupancy flags
//   level         : number of stored entries (0..DEPTH)
module biriscv_commit_trace_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush,
  input  logic               push,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W:0]   level
);

  // One extra pointer bit distinguishes full from empty when low bits match.
  logic [DEPTH_W:0] wr_ptr;
  logic [DEPTH_W:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_W] != rd_ptr[DEPTH_W]) &&
                 (wr_ptr[DEPTH_W-1:0] == rd_ptr[DEPTH_W-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop frees the slot the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rd_data = empty ? '0 : mem[rd_ptr[DEPTH_W-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: stale entries are never visible while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr[DEPTH_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/biriscv_commit_trace.sv
// rtl/biriscv_commit_trace.sv - commit/writeback retire-record capture and trace drain
// Option macro: BIRISCV_COMMIT_TRACE_CSR_EN (store and present CSR write fields)
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   enable_i, clear_i     : capture enable, synchronous flush of FIFO/counters/overflow
//   *_wb_i                : commit port (valid, rd, result, pc, opcode, exception, csr)
//   trace_valid_o/accept_i: head record handshake; trace_* carry the head record
//   instret_o             : commits without exception (wraps)
//   drop_count_o          : records lost while full (saturating)
//   overflow_o            : sticky drop indicator
//   level_o               : FIFO occupancy
module biriscv_commit_trace
  import biriscv_defs::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic               valid_wb_i,
  input  logic [4:0]         rd_wb_i,
  input  logic [31:0]        result_wb_i,
  input  logic [31:0]        pc_wb_i,
  input  logic [31:0]        opcode_wb_i,
  input  logic [5:0]         exception_wb_i,
  input  logic               csr_write_wb_i,
  input  logic [11:0]        csr_waddr_wb_i,
  input  logic [31:0]        csr_wdata_wb_i,
  output logic               trace_valid_o,
  input  logic               trace_accept_i,
  output logic [31:0]        trace_pc_o,
  output logic [31:0]        trace_opcode_o,
  output logic [4:0]         trace_rd_o,
  output logic [31:0]        trace_result_o,
  output logic [5:0]         trace_exception_o,
  output logic               trace_csr_write_o,
  output logic [11:0]        trace_csr_waddr_o,
  output logic [31:0]        trace_csr_wdata_o,
  output logic [31:0]        instret_o,
  output logic [15:0]        drop_count_o,
  output logic               overflow_o,
  output logic [DEPTH_W:0]   level_o
);

  logic                   capture_w;
  logic                   retire_w;
  logic                   drop_w;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [TRACE_REC_W-1:0] wr_rec;
  logic [TRACE_REC_W-1:0] rd_rec;

  // Faults arrive with valid deasserted, so a non-zero exception alone captures.
  assign capture_w = enable_i & (valid_wb_i | (|exception_wb_i));
  assign retire_w  = enable_i & valid_wb_i & (exception_wb_i == EXCEPTION_NONE);
  // Full and not popping this cycle: the record has nowhere to go.
  assign drop_w    = capture_w & fifo_full & ~trace_accept_i;

  always_comb begin
    wr_rec = '0;
    wr_rec[TRACE_PC_LSB     +: 32]          = pc_wb_i;
    wr_rec[TRACE_OPCODE_LSB +: 32]          = opcode_wb_i;
    wr_rec[TRACE_RD_LSB     +: 5]           = rd_wb_i;
    wr_rec[TRACE_RESULT_LSB +: 32]          = result_wb_i;
    wr_rec[TRACE_EXC_LSB    +: EXCEPTION_W] = exception_wb_i;
`ifdef BIRISCV_COMMIT_TRACE_CSR_EN
    wr_rec[TRACE_CSR_WR_LSB]           = csr_write_wb_i;
    wr_rec[TRACE_CSR_WADDR_LSB +: 12]  = csr_waddr_wb_i;
    wr_rec[TRACE_CSR_WDATA_LSB +: 32]  = csr_wdata_wb_i;
`endif
  end

  biriscv_commit_trace_fifo #(
    .WIDTH   (TRACE_REC_W),
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush   (clear_i),
    .push    (capture_w),
    .wr_data (wr_rec),
    .pop     (trace_accept_i),
    .rd_data (rd_rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  assign trace_valid_o     = ~fifo_empty;
  assign trace_pc_o        = rd_rec[TRACE_PC_LSB     +: 32];
  assign trace_opcode_o    = rd_rec[TRACE_OPCODE_LSB +: 32];
  assign trace_rd_o        = rd_rec[TRACE_RD_LSB     +: 5];
  assign trace_result_o    = rd_rec[TRACE_RESULT_LSB +: 32];
  assign trace_exception_o = rd_rec[TRACE_EXC_LSB    +: EXCEPTION_W];

`ifdef BIRISCV_COMMIT_TRACE_CSR_EN
  assign trace_csr_write_o = rd_rec[TRACE_CSR_WR_LSB];
  assign trace_csr_waddr_o = rd_rec[TRACE_CSR_WADDR_LSB +: 12];
  assign trace_csr_wdata_o = rd_rec[TRACE_CSR_WDATA_LSB +: 32];
`else
  assign trace_csr_write_o = 1'b0;
  assign trace_csr_waddr_o = 12'd0;
  assign trace_csr_wdata_o = 32'd0;
  logic unused_csr;
  assign unused_csr = ^{csr_write_wb_i, csr_waddr_wb_i, csr_wdata_wb_i};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instret_o    <= 32'd0;
      drop_count_o <= 16'd0;
      overflow_o   <= 1'b0;
    end else if (clear_i) begin
      instret_o    <= 32'd0;
      drop_count_o <= 16'd0;
      overflow_o   <= 1'b0;
    end else begin
      // Retirement counts even if the record itself was dropped.
      if (retire_w) instret_o <= instret_o + 32'd1;
      if (drop_w) begin
        overflow_o <= 1'b1;
        if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_biriscv_commit_trace.sv
// tb/tb_biriscv_commit_trace.sv - self-checking bench for biriscv_commit_trace
module tb_biriscv_commit_trace;
  import biriscv_defs::*;

  localparam int DEPTH   = 8;
  localparam int DEPTH_W = 3;
`ifdef BIRISCV_COMMIT_TRACE_CSR_EN
  localparam bit CSR_EN = 1'b1;
`else
  localparam bit CSR_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic enable_i, clear_i, valid_wb_i, csr_write_wb_i, trace_accept_i;
  logic [4:0]  rd_wb_i;
  logic [31:0] result_wb_i, pc_wb_i, opcode_wb_i, csr_wdata_wb_i;
  logic [5:0]  exception_wb_i;
  logic [11:0] csr_waddr_wb_i;
  logic        trace_valid_o, trace_csr_write_o, overflow_o;
  logic [31:0] trace_pc_o, trace_opcode_o, trace_result_o, trace_csr_wdata_o, instret_o;
  logic [4:0]  trace_rd_o;
  logic [5:0]  trace_exception_o;
  logic [11:0] trace_csr_waddr_o;
  logic [15:0] drop_count_o;
  logic [DEPTH_W:0] level_o;

  always #5 clk_i = ~clk_i;

  biriscv_commit_trace #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .valid_wb_i(valid_wb_i), .rd_wb_i(rd_wb_i), .result_wb_i(result_wb_i),
    .pc_wb_i(pc_wb_i), .opcode_wb_i(opcode_wb_i), .exception_wb_i(exception_wb_i),
    .csr_write_wb_i(csr_write_wb_i), .csr_waddr_wb_i(csr_waddr_wb_i),
    .csr_wdata_wb_i(csr_wdata_wb_i), .trace_valid_o(trace_valid_o),
    .trace_accept_i(trace_accept_i), .trace_pc_o(trace_pc_o),
    .trace_opcode_o(trace_opcode_o), .trace_rd_o(trace_rd_o),
    .trace_result_o(trace_result_o), .trace_exception_o(trace_exception_o),
    .trace_csr_write_o(trace_csr_write_o), .trace_csr_waddr_o(trace_csr_waddr_o),
    .trace_csr_wdata_o(trace_csr_wdata_o), .instret_o(instret_o),
    .drop_count_o(drop_count_o), .overflow_o(overflow_o), .level_o(level_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] opcode;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [5:0]  exc;
    logic        csr_w;
    logic [11:0] csr_a;
    logic [31:0] csr_d;
  } rec_t;

  typedef struct {
    bit          en;
    bit          valid;
    logic [5:0]  exc;
    logic [31:0] pc;
    bit          acc;
    bit          clr;
    int          e_level;
    int          e_instret;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  rec_t        q[$];
  logic [31:0] m_instret;
  int          m_drop;
  bit          m_ovf;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_instret = 0;
    m_drop    = 0;
    m_ovf     = 0;
  endtask

  task automatic compare_model(input string tag);
    rec_t h;
    h = '{default: '0};
    if (q.size() > 0) h = q[0];
    check({tag, ".level"},   64'(level_o),           64'(q.size()));
    check({tag, ".valid"},   64'(trace_valid_o),     64'(q.size() > 0));
    check({tag, ".pc"},      64'(trace_pc_o),        64'(h.pc));
    check({tag, ".opcode"},  64'(trace_opcode_o),    64'(h.opcode));
    check({tag, ".rd"},      64'(trace_rd_o),        64'(h.rd));
    check({tag, ".result"},  64'(trace_result_o),    64'(h.result));
    check({tag, ".exc"},     64'(trace_exception_o), 64'(h.exc));
    check({tag, ".csr_w"},   64'(trace_csr_write_o), CSR_EN ? 64'(h.csr_w) : 64'd0);
    check({tag, ".csr_a"},   64'(trace_csr_waddr_o), CSR_EN ? 64'(h.csr_a) : 64'd0);
    check({tag, ".csr_d"},   64'(trace_csr_wdata_o), CSR_EN ? 64'(h.csr_d) : 64'd0);
    check({tag, ".instret"}, 64'(instret_o),         64'(m_instret));
    check({tag, ".drop"},    64'(drop_count_o),      64'(m_drop));
    check({tag, ".ovf"},     64'(overflow_o),        64'(m_ovf));
  endtask

  task automatic set_in(input bit en, input bit v, input logic [5:0] exc,
                        input logic [31:0] pc, input bit acc, input bit clr);
    enable_i       = en;
    valid_wb_i     = v;
    exception_wb_i = exc;
    pc_wb_i        = pc;
    trace_accept_i = acc;
    clear_i        = clr;
    opcode_wb_i    = $urandom;
    rd_wb_i        = 5'($urandom);
    result_wb_i    = $urandom;
    csr_write_wb_i = 1'($urandom);
    csr_waddr_wb_i = 12'($urandom);
    csr_wdata_wb_i = $urandom;
  endtask

  // Advance one clock: update the reference model from the driven inputs, then compare.
  task automatic cycle(input string tag);
    rec_t r, dummy;
    r.pc = pc_wb_i; r.opcode = opcode_wb_i; r.rd = rd_wb_i; r.result = result_wb_i;
    r.exc = exception_wb_i; r.csr_w = csr_write_wb_i; r.csr_a = csr_waddr_wb_i;
    r.csr_d = csr_wdata_wb_i;
    if (clear_i) begin
      model_reset();
    end else begin
      if (trace_accept_i && q.size() > 0) dummy = q.pop_front();
      if (enable_i && (valid_wb_i || exception_wb_i != 0)) begin
        if (q.size() < DEPTH) q.push_back(r);
        else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1;
        end
      end
      if (enable_i && valid_wb_i && exception_wb_i == 0) m_instret++;
    end
    @(posedge clk_i);
    #1;
    compare_model(tag);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 1, 6'h00, 32'hA0, 0, 0, 1, 1, 1, 32'hA0};
    vt[1] = '{0, 1, 6'h00, 32'hA1, 0, 0, 1, 1, 1, 32'hA0};
    vt[2] = '{1, 0, 6'h15, 32'hA2, 0, 0, 2, 1, 1, 32'hA0};
    vt[3] = '{1, 1, 6'h02, 32'hA3, 1, 0, 2, 1, 1, 32'hA2};
    vt[4] = '{0, 0, 6'h00, 32'hA4, 1, 0, 1, 1, 1, 32'hA3};
    vt[5] = '{0, 0, 6'h00, 32'hA5, 1, 0, 0, 1, 0, 32'h0};
    vt[6] = '{1, 1, 6'h00, 32'hA6, 1, 0, 1, 2, 1, 32'hA6};
    vt[7] = '{1, 1, 6'h00, 32'hA7, 0, 1, 0, 0, 0, 32'h0};

    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    compare_model("reset");
    rst_i = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].en, vt[i].valid, vt[i].exc, vt[i].pc, vt[i].acc, vt[i].clr);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.t_level", i),   64'(level_o),       64'(vt[i].e_level));
      check($sformatf("vec%0d.t_instret", i), 64'(instret_o),     64'(vt[i].e_instret));
      check($sformatf("vec%0d.t_valid", i),   64'(trace_valid_o), 64'(vt[i].e_valid));
      check($sformatf("vec%0d.t_pc", i),      64'(trace_pc_o),    64'(vt[i].e_pc));
    end

    // Single commit then accept
    set_in(1, 1, 0, 32'h80000000, 0, 0);
    opcode_wb_i = 32'h00a00093; rd_wb_i = 5'd1; result_wb_i = 32'd10;
    cycle("single");
    check("single.valid",   64'(trace_valid_o),  64'd1);
    check("single.pc",      64'(trace_pc_o),     64'h80000000);
    check("single.opcode",  64'(trace_opcode_o), 64'h00a00093);
    check("single.rd",      64'(trace_rd_o),     64'd1);
    check("single.result",  64'(trace_result_o), 64'd10);
    check("single.instret", 64'(instret_o),      64'd1);
    set_in(0, 0, 0, 0, 1, 0);
    cycle("single_pop");
    check("single_pop.valid", 64'(trace_valid_o), 64'd0);
    check("single_pop.level", 64'(level_o),       64'd0);

    // Fault with valid deasserted
    set_in(1, 0, EXCEPTION_FAULT_LOAD, 32'h80000010, 0, 0);
    cycle("fault");
    check("fault.exc",     64'(trace_exception_o), 64'(EXCEPTION_FAULT_LOAD));
    check("fault.pc",      64'(trace_pc_o),        64'h80000010);
    check("fault.instret", 64'(instret_o),         64'd1);
    check("fault.level",   64'(level_o),           64'd1);

    // Overflow: 10 commits, no accept
    set_in(0, 0, 0, 0, 0, 1);
    cycle("clr1");
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, 0, 32'h1000 + 32'(4 * i), 0, 0);
      cycle($sformatf("ovf%0d", i));
    end
    check("ovf.level", 64'(level_o),      64'd8);
    check("ovf.drop",  64'(drop_count_o), 64'd2);
    check("ovf.flag",  64'(overflow_o),   64'd1);
    check("ovf.head",  64'(trace_pc_o),   64'h1000);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 32'h2000 + 32'(4 * i), 1, 0);
      cycle($sformatf("fullpp%0d", i));
      check($sformatf("fullpp%0d.level", i), 64'(level_o),      64'd8);
      check($sformatf("fullpp%0d.drop", i),  64'(drop_count_o), 64'd2);
      check($sformatf("fullpp%0d.head", i),  64'(trace_pc_o),   64'h1000 + 64'(4 * (i + 1)));
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 0, 1, 0);
      cycle($sformatf("drain%0d", i));
    end
    check("drain.level", 64'(level_o), 64'd0);

    // Wrap: push and drain at the same rate
    for (int i = 0; i < 20; i++) begin
      set_in(1, 1, 0, 32'h3000 + 32'(4 * i), 1, 0);
      cycle($sformatf("wrap%0d", i));
      check($sformatf("wrap%0d.head", i), 64'(trace_pc_o), 64'h3000 + 64'(4 * i));
      check($sformatf("wrap%0d.level", i), 64'(level_o), 64'd1);
    end
    set_in(1, 1, 0, 32'h4000, 0, 1);
    cycle("wrapclr");
    check("wrapclr.level",   64'(level_o),    64'd0);
    check("wrapclr.instret", 64'(instret_o),  64'd0);
    check("wrapclr.ovf",     64'(overflow_o), 64'd0);

    // CSR fields
    set_in(1, 1, 0, 32'h5000, 0, 0);
    csr_write_wb_i = 1'b1; csr_waddr_wb_i = 12'h300; csr_wdata_wb_i = 32'h8;
    cycle("csr");
    check("csr.waddr", 64'(trace_csr_waddr_o), CSR_EN ? 64'h300 : 64'd0);
    check("csr.wdata", 64'(trace_csr_wdata_o), CSR_EN ? 64'h8 : 64'd0);
    check("csr.write", 64'(trace_csr_write_o), CSR_EN ? 64'd1 : 64'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 32'h6000 + 32'(4 * i), 0, 0);
      cycle($sformatf("pre_rst%0d", i));
    end
    set_in(0, 0, 0, 0, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    compare_model("async_rst");
    check("async_rst.level", 64'(level_o), 64'd0);
    #1 rst_i = 1'b0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      int acc_bias;
      acc_bias = ((i / 100) % 2 == 0) ? 4 : 1;
      set_in($urandom_range(0, 9) != 0, 1'($urandom),
             ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
             $urandom, $urandom_range(0, 4) < acc_bias, $urandom_range(0, 99) == 0);
      cycle($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
